pwm_ramp_ctrl: RTL
==================

Name: pwm_ramp_ctrl

Overview:
- Configuration sequencer for the pwm block; drives its dataHighStart/dataHighEnd inputs.
- Accepts new edge settings from a host through a valid/ready handshake.
- Applies updates only on PWM period boundaries, so no period is ever glitched.
- Slews dataHighEnd toward its target by a programmable step per period (soft start / soft change) and signals completion.

Parameters:
N, 8, width of PWM counter and edge values (must match the driven pwm instance)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
period_start  input  1  one-cycle strobe, high in the cycle the PWM counter wraps to 0
cfg_valid  input  1  host request valid
cfg_ready  output  1  controller can accept a request
cfg_start  input  N  target dataHighStart
cfg_end  input  N  target dataHighEnd
cfg_step  input  N  dataHighEnd increment per period; 0 = jump directly to target
abort  input  1  cancel ramp; freeze outputs at current values
dataHighStart  output  N  to pwm, registered
dataHighEnd  output  N  to pwm, registered
busy  output  1  request held or ramp in progress
done  output  1  one-cycle pulse when dataHighEnd reaches target

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; dataHighStart=0, dataHighEnd=0, cfg_ready=1, busy=0, done=0; latched targets and step cleared.
- States: IDLE, ARMED, RAMP.
- cfg_ready = (state==IDLE). busy = (state!=IDLE). Both are decoded from registered state.
- IDLE:
  - Handshake when cfg_valid & cfg_ready at a rising edge.
  - Latch tgt_start=cfg_start, tgt_end=cfg_end, step=cfg_step; next state ARMED.
  - A period_start in the acceptance cycle is ignored; the update waits for the next period_start.
  - cfg_valid while not ready is not accepted. Host must hold cfg_valid and its data stable until accepted.
- ARMED, on period_start:
  - dataHighStart <= tgt_start, applied once with no ramp.
  - dataHighEnd takes one step (rule below).
  - Next state: IDLE if target reached, else RAMP.
- RAMP: on each period_start, one step of dataHighEnd only. No change between strobes.
- Step rule:
  - diff = tgt_end - dataHighEnd, computed in N+1-bit signed.
  - If step==0 or |diff|<=step: dataHighEnd <= tgt_end, done pulses in the following cycle (registered), state -> IDLE.
  - Otherwise dataHighEnd <= dataHighEnd ± step, toward the target.
  - Never wraps or overshoots. Values stay within 0..2^N-1.
- Already-at-target request: tgt_end == dataHighEnd still completes on the first period_start. dataHighStart is updated and done pulses.
- done:
  - Exactly 1 cycle, aligned with cfg_ready returning to 1.
  - Never asserted by abort or reset.
  - A new request may be accepted in the same cycle done is high.
- abort:
  - Level-sampled. In ARMED or RAMP it returns state to IDLE next cycle; outputs keep their present values.
  - If abort and period_start coincide, abort wins and no step is taken.
  - abort in IDLE: no effect, and it blocks acceptance in that cycle.
- Outputs change only in the cycle after a period_start edge, apart from reset, so the pwm sees new values from counter value 1 onward.
- dataHighStart > dataHighEnd is passed through unmodified; interpretation belongs to pwm.
- Reset mid-ramp: immediate return to reset values; the pending request is lost.

Test Plan:
- Reset then idle: reset low 3 cycles, release -> dataHighStart=0, dataHighEnd=0, cfg_ready=1, busy=0; period_start strobes every 256 cycles cause no change.
- Direct jump: cfg 50/60/step 0, accepted mid-period -> outputs unchanged until next period_start, then 50/60; done one cycle later; busy high only between acceptance and done.
- Ramp up: from 50/60, request 50/150 step 30 -> dataHighEnd 90, 120, 150 on three successive strobes; done after the third; cfg_ready low throughout.
- Ramp down with remainder: from 150, request end 45 step 40 -> 110, 70, 45 (final partial step, no undershoot); done once.
- Abort: ramp 0->200 step 10, assert abort coincident with the 3rd strobe -> dataHighEnd stays 20, state IDLE, no done; next request accepted.
- Handshake corners: cfg_valid held during RAMP -> not accepted until the done cycle, then latched; async reset low mid-RAMP -> outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// Edge-setting sequencer for a pwm instance: accepts a host request, applies it on
// period boundaries and slews dataHighEnd toward the target one step per period.
module pwm_ramp_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         period_start,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [N-1:0] cfg_start,
  input  logic [N-1:0] cfg_end,
  input  logic [N-1:0] cfg_step,
  input  logic         abort,
  output logic [N-1:0] dataHighStart,
  output logic [N-1:0] dataHighEnd,
  output logic         busy,
  output logic         done
);

  localparam int unsigned DW = N + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RAMP  = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [N-1:0]   tgt_start, tgt_start_next;
  logic [N-1:0]   tgt_end, tgt_end_next;
  logic [N-1:0]   step, step_next;
  logic [N-1:0]   start_next, end_next;
  logic           done_next, ready_next, busy_next;

  logic signed [DW-1:0] diff;
  logic [DW-1:0]        mag;
  logic                 reach;
  logic [N-1:0]         stepped;

  // One slew step: land exactly on target when within reach, never overshoot.
  always_comb begin
    diff    = $signed({1'b0, tgt_end}) - $signed({1'b0, dataHighEnd});
    mag     = diff[DW-1] ? DW'($unsigned(-diff)) : DW'($unsigned(diff));
    reach   = (step == '0) || (mag <= {1'b0, step});
    stepped = tgt_end;
    if (!reach) begin
      stepped = diff[DW-1] ? N'(dataHighEnd - step) : N'(dataHighEnd + step);
    end
  end

  always_comb begin
    state_next     = state;
    tgt_start_next = tgt_start;
    tgt_end_next   = tgt_end;
    step_next      = step;
    start_next     = dataHighStart;
    end_next       = dataHighEnd;
    done_next      = 1'b0;

    unique case (state)
      IDLE: begin
        // abort in IDLE suppresses acceptance for that cycle
        if (cfg_valid && !abort) begin
          tgt_start_next = cfg_start;
          tgt_end_next   = cfg_end;
          step_next      = cfg_step;
          state_next     = ARMED;
        end
      end
      ARMED, RAMP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (period_start) begin
          if (state == ARMED) begin
            start_next = tgt_start;
          end
          end_next = stepped;
          if (reach) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = RAMP;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tgt_start     <= '0;
      tgt_end       <= '0;
      step          <= '0;
      dataHighStart <= '0;
      dataHighEnd   <= '0;
      done          <= 1'b0;
      cfg_ready     <= 1'b1;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      tgt_start     <= tgt_start_next;
      tgt_end       <= tgt_end_next;
      step          <= step_next;
      dataHighStart <= start_next;
      dataHighEnd   <= end_next;
      done          <= done_next;
      cfg_ready     <= ready_next;
      busy          <= busy_next;
    end
  end

endmodule
